// File: rtl/packet_receiver.sv
// packet_receiver: receives SRC/DST/SIZE/DATA/CRC framed bytes, filters on DST and
// drains accepted packets into a downstream FIFO. Define PKT_RX_CRC_CHECK_EN to check CRC.
module packet_receiver #(
    parameter int unsigned       UWIDTH     = 8,
    parameter int unsigned       PTR_OUT_SZ = 4,
    parameter logic [UWIDTH-1:0] NODE_ID    = 'h01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  packet_valid,
    input  logic [UWIDTH-1:0]     packet_in,
    input  logic                  wfull,
    output logic                  winc,
    output logic [PTR_OUT_SZ-1:0] waddr_out,
    output logic [UWIDTH-1:0]     wdata,
    output logic                  pkt_done,
    output logic                  crc_err,
    output logic                  drop_err,
    output logic                  busy
);
    typedef enum logic [2:0] {S_IDLE, S_DST, S_SIZE, S_DATA, S_CRC, S_DRAIN} state_t;
    localparam int unsigned BUF_DEPTH = 10;

    state_t                r_state, w_state_nxt;
    logic                  r_pv_d;
    logic [UWIDTH-1:0]     r_buf [BUF_DEPTH];
    logic [2:0]            r_n, r_cnt;
    logic [3:0]            r_ridx;
    logic [PTR_OUT_SZ-1:0] r_addr_nxt, r_waddr;
    logic [UWIDTH-1:0]     r_wdata;
    logic                  r_winc, r_pkt_done, r_crc_err, r_drop_err, r_busy;

    logic                  w_cap, w_accept, w_pending, w_issue;
    logic [3:0]            w_cap_idx, w_rd_idx, w_total;
    logic                  w_dst_ok, w_crc_bad;
    logic                  w_done_nxt, w_crc_err_nxt, w_drop_err_nxt;

    assign w_total  = 4'd3 + {1'b0, r_n};
    assign w_dst_ok = (r_buf[1] == NODE_ID) || (r_buf[1] == '1);

`ifdef PKT_RX_CRC_CHECK_EN
    logic [UWIDTH-1:0] r_crc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_crc <= '0;
        else if (w_cap)
            r_crc <= (r_state == S_IDLE) ? packet_in : (r_crc ^ packet_in);
    end

    assign w_crc_bad = (r_crc != packet_in);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cap          = 1'b0;
        w_cap_idx      = '0;
        w_accept       = 1'b0;
        w_pending      = 1'b0;
        w_rd_idx       = r_ridx;
        w_done_nxt     = 1'b0;
        w_crc_err_nxt  = 1'b0;
        w_drop_err_nxt = 1'b0;
        // Any gap in packet_valid before the CRC byte aborts the packet.
        if ((r_state inside {S_DST, S_SIZE, S_DATA, S_CRC}) && !packet_valid) begin
            w_drop_err_nxt = 1'b1;
            w_state_nxt    = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (packet_valid && !r_pv_d) begin
                        w_cap       = 1'b1;
                        w_state_nxt = S_DST;
                    end
                end
                S_DST: begin
                    w_cap       = 1'b1;
                    w_cap_idx   = 4'd1;
                    w_state_nxt = S_SIZE;
                end
                S_SIZE: begin
                    w_cap       = 1'b1;
                    w_cap_idx   = 4'd2;
                    w_state_nxt = (packet_in[2:0] != 3'd0) ? S_DATA : S_CRC;
                end
                S_DATA: begin
                    w_cap     = 1'b1;
                    w_cap_idx = 4'd3 + {1'b0, r_cnt};
                    if (r_cnt == r_n - 3'd1)
                        w_state_nxt = S_CRC;
                end
                S_CRC: begin
                    if (w_dst_ok && !w_crc_bad) begin
                        w_accept    = 1'b1;
                        w_pending   = 1'b1;
                        w_rd_idx    = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_crc_err_nxt = w_crc_bad;
                        w_state_nxt   = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (r_ridx == w_total) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_pending = 1'b1;
                    end
                    if (packet_valid && !r_pv_d)
                        w_drop_err_nxt = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_issue = w_pending && !wfull;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv_d <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++)
                r_buf[i] <= '0;
            r_n        <= '0;
            r_cnt      <= '0;
            r_ridx     <= '0;
            r_addr_nxt <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_winc     <= 1'b0;
            r_pkt_done <= 1'b0;
            r_crc_err  <= 1'b0;
            r_drop_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pv_d <= packet_valid;
            if (w_cap)
                r_buf[w_cap_idx] <= packet_in;
            if (w_cap && r_state == S_SIZE) begin
                r_n   <= packet_in[2:0];
                r_cnt <= '0;
            end else if (w_cap && r_state == S_DATA) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_accept)
                r_ridx <= '0;
            // A write is registered here, so winc appears the cycle after wfull is seen low.
            if (w_issue) begin
                r_wdata    <= r_buf[w_rd_idx];
                r_waddr    <= r_addr_nxt;
                r_addr_nxt <= r_addr_nxt + PTR_OUT_SZ'(1);
                r_ridx     <= w_rd_idx + 4'd1;
            end
            r_winc     <= w_issue;
            r_pkt_done <= w_done_nxt;
            r_crc_err  <= w_crc_err_nxt;
            r_drop_err <= w_drop_err_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign winc      = r_winc;
    assign waddr_out = r_waddr;
    assign wdata     = r_wdata;
    assign pkt_done  = r_pkt_done;
    assign crc_err   = r_crc_err;
    assign drop_err  = r_drop_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_packet_receiver.sv
// Bench for packet_receiver: directed and random packets checked against a
// queue-based packet model; follows PKT_RX_CRC_CHECK_EN the same way as the design.
`timescale 1ns/1ps
module tb_packet_receiver;
    localparam int unsigned UW   = 8;
    localparam int unsigned PW   = 4;
    localparam logic [7:0]  NODE = 8'h01;
`ifdef PKT_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b0, packet_valid = 1'b0, wfull = 1'b0;
    logic [7:0] packet_in = '0;
    logic       winc, pkt_done, crc_err, drop_err, busy;
    logic [3:0] waddr_out;
    logic [7:0] wdata;

    packet_receiver #(.UWIDTH(UW), .PTR_OUT_SZ(PW), .NODE_ID(NODE)) dut (
        .clk(clk), .rst(rst), .packet_valid(packet_valid), .packet_in(packet_in),
        .wfull(wfull), .winc(winc), .waddr_out(waddr_out), .wdata(wdata),
        .pkt_done(pkt_done), .crc_err(crc_err), .drop_err(drop_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] obs_data[$];
    logic [3:0] obs_addr[$];
    int n_done, n_crc, n_drop, done_cyc, crcerr_cyc, drop_cyc, first_w, last_w;
    int hold_viol = 0, busy_viol = 0;
    logic [7:0] prev_wdata = '0;
    logic [3:0] prev_waddr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_wdata = '0;
            prev_waddr = '0;
        end else begin
            if (winc) begin
                obs_data.push_back(wdata);
                obs_addr.push_back(waddr_out);
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
            end else if (wdata !== prev_wdata || waddr_out !== prev_waddr) begin
                hold_viol++;
            end
            prev_wdata = wdata;
            prev_waddr = waddr_out;
            if (pkt_done) begin n_done++; done_cyc = cyc; if (busy !== 1'b0) busy_viol++; end
            if (crc_err)  begin n_crc++;  crcerr_cyc = cyc; end
            if (drop_err) begin n_drop++; drop_cyc = cyc; end
        end
    end

    logic [7:0] exp_data[$];
    logic [3:0] exp_addr[$];
    int model_wptr = 0;
    int exp_done, exp_crc, exp_drop, exp_n;
    int crc_sent, low_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_addr.delete();
        n_done = 0; n_crc = 0; n_drop = 0;
        done_cyc = -1; crcerr_cyc = -1; drop_cyc = -1; first_w = -1; last_w = -1;
    endtask

    // Reference: what the node must emit for one packet, from the framing rules.
    task automatic model_pkt(input logic [7:0] b[$], input bit complete);
        int n;
        logic [7:0] c;
        bit crc_ok, dst_ok;
        exp_data.delete(); exp_addr.delete();
        exp_done = 0; exp_crc = 0; exp_drop = 0; exp_n = 0;
        if (!complete) begin
            exp_drop = 1;
            return;
        end
        n = int'(b[2]) % 8;
        c = 8'h00;
        for (int i = 0; i < 3 + n; i++) c = c ^ b[i];
        crc_ok = (c == b[3 + n]);
        dst_ok = (b[1] == NODE) || (b[1] == 8'hFF);
        exp_n  = n;
        if (CRC_EN && !crc_ok) exp_crc = 1;
        if (dst_ok && (crc_ok || !CRC_EN)) begin
            for (int i = 0; i < 3 + n; i++) begin
                exp_data.push_back(b[i]);
                exp_addr.push_back(4'(model_wptr % 16));
                model_wptr++;
            end
            exp_done = 1;
        end
    endtask

    task automatic send(input logic [7:0] b[$], input int cut);
        for (int i = 0; i < cut; i++) begin
            @(posedge clk); #1;
            packet_valid = 1'b1;
            packet_in    = b[i];
            if (i == b.size() - 1) crc_sent = cyc;
        end
        @(posedge clk); #1;
        packet_valid = 1'b0;
        packet_in    = 8'($urandom);
        low_cyc      = cyc;
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_pkt(input string tag, input int stalls, input bit drop_timing);
        chk({tag, " nwrites"}, obs_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            chk({tag, " wdata"}, obs_data[i], exp_data[i]);
            chk({tag, " waddr"}, obs_addr[i], exp_addr[i]);
        end
        chk({tag, " pkt_done count"}, n_done, exp_done);
        chk({tag, " crc_err count"}, n_crc, exp_crc);
        chk({tag, " drop_err count"}, n_drop, exp_drop);
        chk({tag, " output hold"}, hold_viol, 0);
        chk({tag, " busy at done"}, busy_viol, 0);
        chk({tag, " busy idle"}, busy, 1'b0);
        if (exp_done != 0) begin
            chk({tag, " done latency"}, done_cyc - crc_sent, 4 + exp_n + stalls);
            chk({tag, " winc gaps"}, (last_w - first_w + 1) - obs_data.size(), stalls);
        end
        if (exp_crc != 0) chk({tag, " crc_err timing"}, crcerr_cyc - crc_sent, 1);
        if (drop_timing)  chk({tag, " drop_err timing"}, drop_cyc - low_cyc, 1);
    endtask

    logic [7:0] pk[$], pkb[$];
    logic [7:0] c8;
    int n, sel, cut, a_crc;

    initial begin
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset winc", winc, 1'b0);
        chk("reset waddr", waddr_out, 4'h0);
        chk("reset wdata", wdata, 8'h00);
        chk("reset pkt_done", pkt_done, 1'b0);
        chk("reset crc_err", crc_err, 1'b0);
        chk("reset drop_err", drop_err, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b1;
        settle(2);

        pk = {8'h05, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDA};
        clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size()); settle(16);
        check_pkt("good", 0, 1'b0);

        pk = {8'h05, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDB};
        clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size()); settle(16);
        check_pkt("badcrc", 0, 1'b0);

        pk = {8'h02, 8'h01, 8'h00, 8'h03};
        for (int r = 0; r < 6; r++) begin
            clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size()); settle(8);
            check_pkt("zerolen", 0, 1'b0);
        end

        pk = {8'h05, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDA};
        clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size());
        @(posedge clk); #1; wfull = 1'b1;
        settle(3); wfull = 1'b0;
        settle(14);
        check_pkt("stall", 3, 1'b0);

        clear_obs(); model_pkt(pk, 1'b0); send(pk, 4); settle(6);
        check_pkt("trunc", 0, 1'b1);
        clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size()); settle(16);
        check_pkt("after trunc", 0, 1'b0);

        pk = {8'h05, 8'h07, 8'h00, 8'h02};
        clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size()); settle(8);
        check_pkt("dst mismatch", 0, 1'b0);

        pk  = {8'h05, 8'hFF, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
        c8  = 8'h00;
        for (int i = 0; i < 10; i++) c8 = c8 ^ pk[i];
        pk[10] = c8;
        pkb = {8'h09, 8'h01, 8'h00, 8'h08};
        clear_obs(); model_pkt(pk, 1'b1); exp_drop = 1;
        send(pk, pk.size()); a_crc = crc_sent;
        send(pkb, pkb.size()); crc_sent = a_crc;
        settle(16);
        check_pkt("drain overlap", 0, 1'b0);

        for (int p = 0; p < 20; p++) begin
            pk.delete();
            pk.push_back(8'($urandom));
            sel = $urandom_range(0, 3);
            pk.push_back(sel < 2 ? NODE : (sel == 2 ? 8'hFF : 8'($urandom)));
            pk.push_back(8'($urandom));
            n = int'(pk[2]) % 8;
            for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
            c8 = 8'h00;
            for (int i = 0; i < 3 + n; i++) c8 = c8 ^ pk[i];
            if ($urandom_range(0, 3) == 0) c8 = c8 ^ 8'h5A;
            pk.push_back(c8);
            clear_obs();
            if ($urandom_range(0, 5) == 0) begin
                cut = $urandom_range(1, pk.size() - 1);
                model_pkt(pk, 1'b0); send(pk, cut); settle(6);
                check_pkt("rand trunc", 0, 1'b1);
            end else begin
                model_pkt(pk, 1'b1); send(pk, pk.size()); settle(16);
                check_pkt("rand", 0, 1'b0);
            end
        end

        pk = {8'h05, 8'hFF, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
        c8 = 8'h00;
        for (int i = 0; i < 10; i++) c8 = c8 ^ pk[i];
        pk[10] = c8;
        clear_obs(); send(pk, pk.size()); settle(2);
        rst = 1'b0; #1;
        chk("midreset winc", winc, 1'b0);
        chk("midreset waddr", waddr_out, 4'h0);
        chk("midreset busy", busy, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        model_wptr = 0;
        settle(2);
        pk = {8'h02, 8'h01, 8'h00, 8'h03};
        clear_obs(); model_pkt(pk, 1'b1); send(pk, pk.size()); settle(8);
        check_pkt("after reset", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
